// File: rtl/fpnew_noncomp_wb.sv
// fpnew_noncomp_wb: writeback buffer behind the non-computational FP unit.
// Widens each result to FLEN bits (NaN-box / sign-extend / class mask),
// queues it in an in-order FIFO and accumulates sticky exception flags.
// Optional macro FPNEW_NONCOMP_WB_BYPASS_EN adds a same-cycle path from
// input to output when the buffer is empty.

package fpnew_noncomp_wb_pkg;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction
endpackage

module fpnew_noncomp_wb #(
  parameter fpnew_noncomp_wb_pkg::fp_format_e FpFormat = fpnew_noncomp_wb_pkg::FP32,
  parameter int unsigned FLEN  = 64,   // must be >= WIDTH
  parameter int unsigned DEPTH = 2,    // must be >= 1
  parameter type         TagType = logic,
  localparam int unsigned WIDTH = fpnew_noncomp_wb_pkg::fp_width(FpFormat),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic [4:0]       status_i,
  input  logic             extension_bit_i,
  input  logic [9:0]       class_mask_i,
  input  logic             is_class_i,
  input  TagType           tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [FLEN-1:0]  result_o,
  output logic [4:0]       status_o,
  output TagType           tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0]       fflags_o,
  input  logic             fflags_clr_i,
  output logic [CW-1:0]    count_o,
  output logic             busy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [FLEN-1:0] result;
    logic [4:0]      status;
    TagType          tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [4:0]      fflags_q;

  logic [FLEN-1:0] wide_result;
  entry_t          in_entry, head;
  logic            fifo_valid, push, pop, bypass_take, store, fifo_pop, acc;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Widen the raw result into the FLEN-bit register format at push time.
  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    wide_result = '0;
    if (is_class_i) begin
      wide_result = FLEN'(class_mask_i);
    end else begin
      wide_result = {FLEN{extension_bit_i}};
      wide_result[WIDTH-1:0] = result_i;
    end
  end

  assign in_entry   = '{result: wide_result, status: status_i, tag: tag_i};
  assign fifo_valid = (count_q != '0);

  // Ready depends only on occupancy, never on out_ready_i.
  assign in_ready_o = (count_q < CW'(DEPTH)) & ~rst_i;
  assign push       = in_valid_i & in_ready_o;

  // Select the head entry (or the bypassed input) and force zeros when empty.
  always_comb begin
    out_valid_o = fifo_valid;
    head        = fifo_valid ? mem_q[rd_ptr_q] : '0;
    bypass_take = 1'b0;
`ifdef FPNEW_NONCOMP_WB_BYPASS_EN
    if (!fifo_valid && in_valid_i && !flush_i && !rst_i) begin
      out_valid_o = 1'b1;
      head        = in_entry;
      bypass_take = out_ready_i;
    end
`endif
  end

  assign result_o = head.result;
  assign status_o = head.status;
  assign tag_o    = head.tag;

  assign pop      = out_valid_o & out_ready_i & ~rst_i;
  assign store    = push & ~flush_i & ~bypass_take;
  assign fifo_pop = pop & fifo_valid & ~flush_i;
  assign acc      = pop & ~flush_i;

  // Entry storage; contents are qualified by count_q, so no reset is needed.
  always_ff @(posedge clk_i) begin
    // NOTE: memory array is deliberately not reset; valid tracking lives in count_q.
    if (store) mem_q[wr_ptr_q] <= in_entry;
  end

  // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store)    wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({store, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags: clear first, then accumulate the popped status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_q <= acc ? status_o : 5'h00;
    end else if (acc) begin
      fflags_q <= fflags_q | status_o;
    end
  end

  assign fflags_o = fflags_q;
  assign count_o  = count_q;
  assign busy_o   = (count_q != '0);

endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// Testbench for fpnew_noncomp_wb (FP32, FLEN=64, DEPTH=2, 4-bit tag).
// A negedge monitor keeps a queue-based reference model and compares every
// cycle; table vectors and hand-written sequences drive the stimulus.

module tb_fpnew_noncomp_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_i;
  logic [4:0]  status_i;
  logic        ext;
  logic [9:0]  class_mask;
  logic        is_class;
  logic [3:0]  tag_i;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [63:0] result_o;
  logic [4:0]  status_o;
  logic [3:0]  tag_o;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic [1:0]  count;
  logic        busy;

  logic [63:0] exp_res;
  bit          mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  st;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  logic [4:0] model_ff;

  typedef struct {
    logic [31:0] res;
    logic        ext;
    logic [9:0]  mask;
    logic        is_cls;
    logic [4:0]  st;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  fpnew_noncomp_wb #(
    .FpFormat (fpnew_noncomp_wb_pkg::FP32),
    .FLEN     (64),
    .DEPTH    (2),
    .TagType  (logic [3:0])
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .result_i        (result_i),
    .status_i        (status_i),
    .extension_bit_i (ext),
    .class_mask_i    (class_mask),
    .is_class_i      (is_class),
    .tag_i           (tag_i),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .flush_i         (flush),
    .result_o        (result_o),
    .status_o        (status_o),
    .tag_o           (tag_o),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .fflags_o        (fflags),
    .fflags_clr_i    (fflags_clr),
    .count_o         (count),
    .busy_o          (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] r, input logic e, input logic [9:0] m,
                       input logic c, input logic [4:0] s, input logic [3:0] t,
                       input logic [63:0] x);
    in_valid = 1'b1; result_i = r; ext = e; class_mask = m; is_class = c;
    status_i = s; tag_i = t; exp_res = x;
  endtask

  task automatic idle();
    in_valid = 1'b0; result_i = '0; ext = 1'b0; class_mask = '0; is_class = 1'b0;
    status_i = '0; tag_i = '0; exp_res = '0;
  endtask

  // Reference model: compare outputs mid-cycle, then advance the model.
  always @(negedge clk) begin
    exp_t head, in_e;
    bit   ev, byp, pop, accept;
    if (mon_en) begin
      in_e.res = exp_res; in_e.st = status_i; in_e.tag = tag_i;
      byp = 1'b0;
`ifdef FPNEW_NONCOMP_WB_BYPASS_EN
      byp = (sb.size() == 0) && in_valid && !flush && !rst;
`endif
      ev = (sb.size() != 0) || byp;
      if (byp) head = in_e;
      else if (sb.size() != 0) head = sb[0];
      else begin head.res = '0; head.st = '0; head.tag = '0; end

      check("in_ready", 64'(in_ready), 64'(!rst && sb.size() < 2));
      check("out_valid", 64'(out_valid), 64'(ev));
      check("result", result_o, head.res);
      check("status", 64'(status_o), 64'(head.st));
      check("tag", 64'(tag_o), 64'(head.tag));
      check("count", 64'(count), 64'(sb.size()));
      check("busy", 64'(busy), 64'(sb.size() != 0));
      check("fflags", 64'(fflags), 64'(model_ff));

      pop    = ev && out_ready && !rst;
      accept = in_valid && (sb.size() < 2) && !rst;
      if (rst) begin
        sb.delete();
        model_ff = '0;
      end else begin
        if (fflags_clr) model_ff = (pop && !flush) ? head.st : 5'h00;
        else if (pop && !flush) model_ff = model_ff | head.st;
        if (flush) begin
          sb.delete();
        end else if (!(byp && out_ready)) begin
          if (pop) void'(sb.pop_front());
          if (accept) sb.push_back(in_e);
        end
      end
    end
  end

  initial begin
    model_ff = '0;
    vecs[0] = '{32'h3F800000, 1'b1, 10'h000, 1'b0, 5'h00, 64'hFFFFFFFF_3F800000};
    vecs[1] = '{32'h00000001, 1'b0, 10'h000, 1'b0, 5'h01, 64'h00000000_00000001};
    vecs[2] = '{32'hDEADBEEF, 1'b1, 10'h040, 1'b1, 5'h00, 64'h00000000_00000040};
    vecs[3] = '{32'h7FC00000, 1'b1, 10'h000, 1'b0, 5'h10, 64'hFFFFFFFF_7FC00000};
    vecs[4] = '{32'h80000000, 1'b0, 10'h000, 1'b0, 5'h00, 64'h00000000_80000000};
    vecs[5] = '{32'h12345678, 1'b1, 10'h200, 1'b1, 5'h02, 64'h00000000_00000200};
    vecs[6] = '{32'hFFFFFFFF, 1'b0, 10'h000, 1'b0, 5'h04, 64'h00000000_FFFFFFFF};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
    idle();
    cyc();
    mon_en = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("reset_count", 64'(count), 64'h0);
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_result", result_o, 64'h0);
    check("reset_in_ready", 64'(in_ready), 64'h1);

    // Latency: pushed entry appears on the next cycle with the widened value.
    drive(32'h3F800000, 1'b1, 10'h0, 1'b0, 5'h00, 4'h0, 64'hFFFFFFFF_3F800000);
    cyc();
    idle();
    check("lat_valid", 64'(out_valid), 64'h1);
    check("lat_result", result_o, 64'hFFFFFFFF_3F800000);
    out_ready = 1'b1;
    cyc();

    // Streaming table vectors with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].res, vecs[i].ext, vecs[i].mask, vecs[i].is_cls, vecs[i].st,
            4'(i), vecs[i].exp);
      cyc();
    end
    idle();
    cyc();
    cyc();
    check("table_fflags", 64'(fflags), 64'h17);

    // Back-pressure: fill, hold tag 3, then drain in order.
    out_ready = 1'b0;
    drive(32'h1, 1'b0, 10'h0, 1'b0, 5'h00, 4'd1, 64'h1);
    cyc();
    drive(32'h2, 1'b0, 10'h0, 1'b0, 5'h00, 4'd2, 64'h2);
    cyc();
    drive(32'h3, 1'b0, 10'h0, 1'b0, 5'h00, 4'd3, 64'h3);
    check("full_in_ready", 64'(in_ready), 64'h0);
    check("full_count", 64'(count), 64'h2);
    check("full_head_tag", 64'(tag_o), 64'h1);
    cyc();
    out_ready = 1'b1;
    cyc();
    check("drain_tag2", 64'(tag_o), 64'h2);
    cyc();
    idle();
    check("drain_tag3", 64'(tag_o), 64'h3);
    cyc();
    check("drain_empty", 64'(out_valid), 64'h0);

    // Sticky flags: accumulate, clear-with-pop, clear alone.
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    out_ready = 1'b0;
    drive(32'h0, 1'b0, 10'h0, 1'b0, 5'h10, 4'd4, 64'h0);
    cyc();
    drive(32'h0, 1'b0, 10'h0, 1'b0, 5'h01, 4'd5, 64'h0);
    cyc();
    idle();
    out_ready = 1'b1;
    cyc();
    cyc();
    check("ff_accum", 64'(fflags), 64'h11);
    out_ready = 1'b0;
    drive(32'h0, 1'b0, 10'h0, 1'b0, 5'h04, 4'd6, 64'h0);
    cyc();
    idle();
    out_ready = 1'b1;
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    out_ready = 1'b0;
    check("ff_clr_pop", 64'(fflags), 64'h04);
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    check("ff_clr_alone", 64'(fflags), 64'h00);

    // Flush while full, with a pop and push attempt in the same cycle.
    drive(32'h0, 1'b0, 10'h0, 1'b0, 5'h01, 4'd7, 64'h0);
    cyc();
    idle();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    drive(32'h0, 1'b0, 10'h0, 1'b0, 5'h10, 4'd8, 64'h0);
    cyc();
    drive(32'h0, 1'b0, 10'h0, 1'b0, 5'h10, 4'd9, 64'h0);
    cyc();
    check("pre_flush_count", 64'(count), 64'h2);
    out_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    check("flush_count", 64'(count), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_fflags", 64'(fflags), 64'h01);

    // Reset mid-operation with one entry stored and all flags set.
    drive(32'h0, 1'b0, 10'h0, 1'b0, 5'h1F, 4'd10, 64'h0);
    cyc();
    idle();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    drive(32'h5, 1'b1, 10'h0, 1'b0, 5'h02, 4'd11, 64'hFFFFFFFF_00000005);
    cyc();
    idle();
    check("pre_rst_count", 64'(count), 64'h1);
    check("pre_rst_fflags", 64'(fflags), 64'h1F);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_count", 64'(count), 64'h0);
    check("post_rst_valid", 64'(out_valid), 64'h0);
    check("post_rst_busy", 64'(busy), 64'h0);
    check("post_rst_fflags", 64'(fflags), 64'h0);
    check("post_rst_result", result_o, 64'h0);
    check("post_rst_tag", 64'(tag_o), 64'h0);
    check("post_rst_in_ready", 64'(in_ready), 64'h1);

`ifdef FPNEW_NONCOMP_WB_BYPASS_EN
    // Bypass: empty buffer, consumer ready, output in the same cycle.
    out_ready = 1'b1;
    drive(32'h40000000, 1'b1, 10'h0, 1'b0, 5'h01, 4'd12, 64'hFFFFFFFF_40000000);
    #1;
    check("byp_valid", 64'(out_valid), 64'h1);
    check("byp_result", result_o, 64'hFFFFFFFF_40000000);
    cyc();
    idle();
    check("byp_count", 64'(count), 64'h0);
    check("byp_fflags", 64'(fflags), 64'h01);
    out_ready = 1'b0;
`endif

    cyc();
    cyc();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
